// File: rtl/escalonador_pkg.sv
// Shared encodings for the context-switch controller: FSM states and pid constants.
package escalonador_pkg;
    localparam int PID_W = 2;
    localparam logic [PID_W-1:0] PID_OS = 2'd0;

    typedef enum logic [1:0] {
        S_OS    = 2'd0,
        S_USER  = 2'd1,
        S_TROCA = 2'd2
    } state_t;
endpackage

// File: rtl/escalonador_processos_contador.sv
// Quantum counter: counts enabled cycles of a user slice and flags the last one.
module contador_quantum #(
    parameter int QUANTUM = 64,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expira
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expira = en && (cnt_q == LAST);
endmodule

// File: rtl/escalonador_processos.sv
// Context-switch controller: tracks the owning pid, preempts user slices and
// emits a one-cycle troca_ctx strobe for every switch.
module escalonador_processos
    import escalonador_pkg::*;
#(
    parameter int QUANTUM = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preemp_mode,
    input  logic             HALT,
    input  logic             WAIT,
    input  logic             Set_ctx,
    input  logic             Set_pid_0,
    input  logic [PID_W-1:0] ctx_pid,
    output logic [PID_W-1:0] id_proc,
    output logic             troca_ctx,
    output logic             preemptado
);
    state_t           state_q, state_d;
    logic [PID_W-1:0] id_proc_q, id_proc_d;
    logic             troca_ctx_q, troca_ctx_d;
    logic             preemptado_q, preemptado_d;
    logic             cnt_en, cnt_clr, expira;

    assign cnt_en = (state_q == S_USER) && preemp_mode && !WAIT;

    contador_quantum #(
        .QUANTUM (QUANTUM),
        .CNT_W   (CNT_W)
    ) u_contador (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expira (expira)
    );

    always_comb begin
        state_d      = state_q;
        id_proc_d    = id_proc_q;
        preemptado_d = preemptado_q;
        case (state_q)
            S_OS: begin
                // HALT and Set_pid_0 are no-ops while the OS owns the core
                if (Set_ctx && (ctx_pid != PID_OS)) begin
                    id_proc_d    = ctx_pid;
                    preemptado_d = 1'b0;
                    state_d      = S_TROCA;
                end
            end
            S_USER: begin
                if (HALT || Set_pid_0) begin
                    id_proc_d    = PID_OS;
                    preemptado_d = 1'b0;
                    state_d      = S_TROCA;
                end else if (expira) begin
                    id_proc_d    = PID_OS;
                    preemptado_d = 1'b1;
                    state_d      = S_TROCA;
                end
            end
            S_TROCA: state_d = (id_proc_q == PID_OS) ? S_OS : S_USER;
            default: state_d = S_OS;
        endcase
        troca_ctx_d = (state_d == S_TROCA);
        cnt_clr     = (state_d == S_TROCA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_OS;
            id_proc_q    <= PID_OS;
            troca_ctx_q  <= 1'b0;
            preemptado_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_proc_q    <= id_proc_d;
            troca_ctx_q  <= troca_ctx_d;
            preemptado_q <= preemptado_d;
        end
    end

    assign id_proc    = id_proc_q;
    assign troca_ctx  = troca_ctx_q;
    assign preemptado = preemptado_q;
endmodule

// File: doc/escalonador_processos.md
# escalonador_processos

Context-switch controller that sits directly upstream of the processor core and drives its `id_proc` and `troca_ctx` inputs. It tracks which process owns the core. It enforces a preemption quantum on user processes, returns control to the OS (pid 0) on syscall, HALT or quantum expiry, and launches the user process the OS selects through `Set_ctx`. It consumes the core's control-unit outputs (`HALT`, `WAIT`, `Set_ctx`, `Set_pid_0`) and the low bits of `rl2out`.

## Interface
Parameters:
- `QUANTUM`, default 64: user-process time slice in clock cycles; legal range 2..65535.
- `CNT_W`, default 16: quantum counter width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `preemp_mode`  in  1  1 = quantum preemption enabled; 0 = cooperative (no expiry).
- `HALT`  in  1  the running process executed halt.
- `WAIT`  in  1  the core is stalled on I/O; freezes the quantum count.
- `Set_ctx`  in  1  the OS requests a switch to `ctx_pid`.
- `Set_pid_0`  in  1  a user process issued a syscall; return to the OS.
- `ctx_pid`  in  2  target pid, taken from `rl2out[1:0]` and sampled with `Set_ctx`.
- `id_proc`  out  2  pid currently owning the core; registered.
- `troca_ctx`  out  1  one-cycle switch strobe to `gerencia_PC`; registered.
- `preemptado`  out  1  sticky; 1 = the last return to the OS was caused by quantum expiry.

## Operation
- States: `S_OS` (pid 0 running), `S_USER` (pid 1..3 running), `S_TROCA` (switch cycle).
- Reset values: state `S_OS`, `id_proc` = 0, `troca_ctx` = 0, `preemptado` = 0, counter = 0.
- `S_OS`:
  - `Set_ctx` with `ctx_pid` != 0: latch `ctx_pid` and go to `S_TROCA`.
  - `Set_ctx` with `ctx_pid` = 0: ignored.
  - `HALT`: stay in `S_OS`, no switch; the system is halted.
  - `Set_pid_0` in this state is ignored.
- `S_USER`, event priority: `HALT` > `Set_pid_0` > quantum expiry. Any of the three sets next pid = 0 and moves to `S_TROCA`.
  - `Set_ctx` is ignored in this state (privileged to the OS).
- Quantum counter:
  - Counts only in `S_USER`, only when `preemp_mode` = 1 and `WAIT` = 0.
  - Expiry occurs when the counter = `QUANTUM`-1 on a counting cycle.
  - Cleared on every entry to `S_TROCA`.
  - `preemp_mode` falling mid-slice freezes the counter without clearing it.
- `S_TROCA`:
  - `id_proc` already shows the new pid and `troca_ctx` = 1.
  - The next state is `S_OS` if the new pid = 0, else `S_USER`.
  - All inputs are ignored during `S_TROCA`.
- `preemptado`:
  - Set to 1 on a switch caused by quantum expiry.
  - Cleared to 0 on a switch caused by `HALT` or `Set_pid_0`, and on `Set_ctx` acceptance.
- A `HALT` that returns a user process to the OS does not halt the system; the OS decides.

## Timing
- Request sampled at clock edge N. After edge N: `id_proc` = new pid, `troca_ctx` = 1, state = `S_TROCA`.
- After edge N+1: `troca_ctx` = 0 and the new process runs. `gerencia_PC` commits the switch at edge N+1.
- `troca_ctx` is never high for two consecutive cycles.
- Minimum spacing between switches is 2 cycles.
- Quantum: entry to `S_USER` after edge M, with no `WAIT` and `preemp_mode` = 1.
  - Expiry is sampled at edge M+`QUANTUM`.
  - `troca_ctx` is high in the following cycle.
- Reset mid-switch aborts the switch: `id_proc` = 0 and `troca_ctx` = 0 after the reset edge.
- Simultaneous `HALT`, `Set_pid_0` and expiry on one edge produce one switch, with the cause recorded per priority (`preemptado` = 0 if `HALT` or `Set_pid_0` is present).

## Structure
- Shared package `escalonador_pkg`:
  - state encoding `S_OS` / `S_USER` / `S_TROCA`;
  - `PID_OS` = 2'd0;
  - `PID_W` = 2.
- Sub-module `contador_quantum`:
  - inputs: `clk`, `reset`, `clr`, `en`;
  - output: `expira` (combinational, counter = `QUANTUM`-1 and `en`).
- The top level holds the FSM, the next-pid register and `preemptado`.

## Test plan
- Reset, then `Set_ctx` with `ctx_pid` = 2 → after 1 edge `id_proc` = 2 and `troca_ctx` = 1 for exactly 1 cycle; next cycle `troca_ctx` = 0.
- pid 1 running, `preemp_mode` = 1, `QUANTUM` = 8, no `WAIT` → `troca_ctx` high 8 cycles after entry, `id_proc` = 0, `preemptado` = 1.
- Same as above, with `WAIT` high for 5 cycles mid-slice → expiry delayed by exactly 5 cycles.
- pid 3 running, `Set_pid_0` and expiry on the same edge → one switch to 0, `preemptado` = 0.
- `S_OS`: `Set_ctx` with `ctx_pid` = 0, then `HALT` → no `troca_ctx` pulse ever, `id_proc` stays 0.
- `reset` asserted during the `S_TROCA` cycle → next cycle `id_proc` = 0, `troca_ctx` = 0, `preemptado` = 0.
